aes_128_seq_ctrl: RTL and testbench

AES_128_SEQ_CTRL -- requirements
Module: aes_128_seq_ctrl

---
 rtl/aes_128_seq_ctrl_if.sv | 33 +++
 rtl/aes_128_seq_ctrl.sv | 111 +++++++++++
 tb/tb_aes_128_seq_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_128_seq_ctrl_if.sv
// Handshake, ciphertext and round-core/key-schedule signals of the AES-128 sequencer.
// master = requester plus external round core; slave = sequencer.
interface aes_128_seq_ctrl_if #(
  parameter int RND_W = 4
);
  logic             start;
  logic             abort;
  logic [127:0]     key_in;
  logic [127:0]     pt_in;
  logic             ready;
  logic             busy;
  logic [RND_W-1:0] round;
  logic [127:0]     ct_out;
  logic             ct_valid;
  logic             ct_ack;
  logic [127:0]     rnd_state;
  logic [127:0]     rnd_key;
  logic             rnd_last;
  logic [127:0]     rnd_result;
  logic [127:0]     ks_key;
  logic [7:0]       ks_rcon;
  logic [127:0]     ks_next;

  modport master (
    output start, abort, key_in, pt_in, ct_ack, rnd_result, ks_next,
    input  ready, busy, round, ct_out, ct_valid, rnd_state, rnd_key, rnd_last, ks_key, ks_rcon
  );

  modport slave (
    input  start, abort, key_in, pt_in, ct_ack, rnd_result, ks_next,
    output ready, busy, round, ct_out, ct_valid, rnd_state, rnd_key, rnd_last, ks_key, ks_rcon
  );
endinterface

// File: rtl/aes_128_seq_ctrl.sv
// AES-128 sequencer: one external round per cycle, ct_valid NUM_ROUNDS cycles after an accepted start.
// start only taken when ready; ct_valid/ct_out hold until ct_ack (or abort); abort cancels a run.
module aes_128_seq_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int RND_W      = 4
) (
  input logic               S_AXI_ACLK,
  input logic               S_AXI_ARESETN,
  aes_128_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS);

  fsm_t             fsm_q;
  fsm_t             fsm_d;
  logic [127:0]     st_q;
  logic [127:0]     key_q;
  logic [127:0]     ct_q;
  logic [RND_W-1:0] round_q;
  logic             take;

  // abort outranks start even while idle, so nothing is captured
  assign take = (fsm_q == IDLE) && bus.start && !bus.abort;

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) fsm_q <= IDLE;
    else                fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (take) fsm_d = ROUND;
      ROUND: begin
        if (bus.abort)                fsm_d = IDLE;
        else if (round_q == LAST_RND) fsm_d = DONE;
      end
      DONE:    if (bus.ct_ack || bus.abort) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ready    = (fsm_q == IDLE);
    bus.busy     = (fsm_q == ROUND);
    bus.ct_valid = (fsm_q == DONE);
    bus.rnd_last = (fsm_q == ROUND) && (round_q == LAST_RND);
    bus.ks_rcon  = 8'h00;
    case (round_q)
      RND_W'(1):  bus.ks_rcon = 8'h01;
      RND_W'(2):  bus.ks_rcon = 8'h02;
      RND_W'(3):  bus.ks_rcon = 8'h04;
      RND_W'(4):  bus.ks_rcon = 8'h08;
      RND_W'(5):  bus.ks_rcon = 8'h10;
      RND_W'(6):  bus.ks_rcon = 8'h20;
      RND_W'(7):  bus.ks_rcon = 8'h40;
      RND_W'(8):  bus.ks_rcon = 8'h80;
      RND_W'(9):  bus.ks_rcon = 8'h1b;
      RND_W'(10): bus.ks_rcon = 8'h36;
      default:    bus.ks_rcon = 8'h00;
    endcase
  end

  // round_q drops to 0 on leaving ROUND so it reads 0 in IDLE/DONE
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      st_q    <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      round_q <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (take) begin
            st_q    <= bus.pt_in ^ bus.key_in;
            key_q   <= bus.key_in;
            round_q <= RND_W'(1);
          end
        end
        ROUND: begin
          if (bus.abort) begin
            round_q <= '0;
          end else begin
            st_q  <= bus.rnd_result;
            key_q <= bus.ks_next;
            if (round_q == LAST_RND) begin
              ct_q    <= bus.rnd_result;
              round_q <= '0;
            end else begin
              round_q <= round_q + RND_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.round     = round_q;
  assign bus.ct_out    = ct_q;
  assign bus.rnd_state = st_q;
  assign bus.rnd_key   = bus.ks_next;
  assign bus.ks_key    = key_q;

endmodule

// File: tb/tb_aes_128_seq_ctrl.sv
// Bench for aes_128_seq_ctrl: models the external AES round core and key-schedule step,
// and compares every result with a whole-cipher reference computed from a full key expansion.
module tb_aes_128_seq_ctrl;

  localparam int NR = 10;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  logic [127:0] last_ct;

  aes_128_seq_ctrl_if #(.RND_W(4)) bus();

  aes_128_seq_ctrl #(.NUM_ROUNDS(NR), .RND_W(4)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .bus           (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from first principles: GF(2^8) inverse (x^254) then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s = x;
    logic [7:0] p = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      p = gmul(p, s);
    end
    return p ^ rol8(p, 1) ^ rol8(p, 2) ^ rol8(p, 3) ^ rol8(p, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = sbox(st[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i] ^ rk[127-8*i -: 8];
    return o;
  endfunction

  function automatic logic [127:0] ks_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3, tmp, n0, n1, n2, n3;
    w3  = k[31:0];
    tmp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0  = k[127:96] ^ tmp;
    n1  = k[95:64] ^ n0;
    n2  = k[63:32] ^ n1;
    n3  = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] rk [NR+1];
    logic [127:0] s;
    logic [7:0]   rc = 8'h01;
    rk[0] = key;
    for (int r = 1; r <= NR; r++) begin
      rk[r] = ks_step(rk[r-1], rc);
      rc    = xt(rc);
    end
    s = pt ^ rk[0];
    for (int r = 1; r <= NR; r++) s = aes_round(s, rk[r], r == NR);
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // external round core and key-schedule step
  assign bus.rnd_result = aes_round(bus.rnd_state, bus.rnd_key, bus.rnd_last);
  assign bus.ks_next    = ks_step(bus.ks_key, bus.ks_rcon);

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    check("rst_ready", bus.ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.ct_valid, 0);
    check("rst_round", bus.round, 0);
    check("rst_ct", bus.ct_out, 0);
    check("rst_state", bus.rnd_state, 0);
    check("rst_key", bus.ks_key, 0);
    check("rst_rcon", bus.ks_rcon, 0);
    last_ct = '0;
  endtask

  // stop_at>0: abort (or reset if use_rst) while in that round
  task automatic run(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] exp,
                     input bit tog, input int stop_at, input bit use_rst);
    logic [7:0] rc = 8'h01;
    bus.start  = 1'b1;
    bus.key_in = key;
    bus.pt_in  = pt;
    tick();
    bus.start = 1'b0;
    for (int r = 1; r <= NR; r++) begin
      check("round", bus.round, r);
      check("rcon", bus.ks_rcon, rc);
      check("last", bus.rnd_last, r == NR);
      check("flags_busy", {bus.ready, bus.busy, bus.ct_valid}, 3'b010);
      if (tog) begin
        bus.key_in = rand128();
        bus.pt_in  = rand128();
      end
      if (r == stop_at) begin
        if (use_rst) rst_n = 1'b0;
        else         bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        rst_n     = 1'b1;
        if (use_rst) begin
          check_reset();
        end else begin
          check("abort_ready", bus.ready, 1);
          check("abort_round", bus.round, 0);
          check("abort_valid", bus.ct_valid, 0);
          check("abort_ct", bus.ct_out, last_ct);
          for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_idle", {bus.ready, bus.busy, bus.ct_valid}, 3'b100);
          end
        end
        return;
      end
      tick();
      rc = xt(rc);
    end
    check("ct_valid", bus.ct_valid, 1);
    check("flags_done", {bus.ready, bus.busy, bus.ct_valid}, 3'b001);
    check("ct", bus.ct_out, exp);
    last_ct = exp;
  endtask

  task automatic ack(input bit with_start, input bit via_abort);
    bus.ct_ack = !via_abort;
    bus.abort  = via_abort;
    bus.start  = with_start;
    tick();
    bus.ct_ack = 1'b0;
    bus.abort  = 1'b0;
    bus.start  = 1'b0;
    check("ack_flags", {bus.ready, bus.busy, bus.ct_valid}, 3'b100);
    check("ack_round", bus.round, 0);
    check("ack_ct_kept", bus.ct_out, last_ct);
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    logic [127:0] k, p;
    n_chk      = 0;
    n_pass     = 0;
    last_ct    = '0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.ct_ack = 1'b0;
    bus.key_in = rand128();
    bus.pt_in  = rand128();
    tick();
    tick();
    rst_n = 1'b1;
    check_reset();

    run(C1_KEY, C1_PT, C1_CT, 1'b0, 0, 1'b0);
    ack(1'b0, 1'b0);

    // hold without ack, pulsing start randomly
    run(B_KEY, B_PT, B_CT, 1'b0, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      bus.start = 1'($urandom_range(0, 1));
      tick();
      check("hold_flags", {bus.ready, bus.busy, bus.ct_valid}, 3'b001);
      check("hold_ct", bus.ct_out, B_CT);
    end
    bus.start = 1'b0;
    ack(1'b1, 1'b0);

    // abort while idle outranks start
    bus.start  = 1'b1;
    bus.abort  = 1'b1;
    bus.key_in = rand128();
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("idle_abort_flags", {bus.ready, bus.busy, bus.ct_valid}, 3'b100);
    check("idle_abort_round", bus.round, 0);

    run(rand128(), rand128(), '0, 1'b0, 5, 1'b0);
    run(C1_KEY, C1_PT, C1_CT, 1'b0, 0, 1'b0);
    ack(1'b0, 1'b1);

    run(B_KEY, B_PT, B_CT, 1'b0, 7, 1'b1);
    run(C1_KEY, C1_PT, C1_CT, 1'b0, 0, 1'b0);
    ack(1'b0, 1'b0);

    // back-to-back random runs with inputs toggled mid-run
    for (int i = 0; i < 4; i++) begin
      k = rand128();
      p = rand128();
      run(k, p, aes_ref(k, p), 1'b1, 0, 1'b0);
      ack(i[0], 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=%0d exp=%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
